// File: rtl/fc_pkg.sv
// Shared types and constants for the FC feed sequencer slice.
// Holds the control state encoding, default sizes and the fc_vec element slicing rule.
package fc_pkg;

    localparam int N_IN_DEF = 9;
    localparam int DW_DEF   = 8;
    localparam int OW_DEF   = 16;
    localparam int WD_W     = 16;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_CLEAR,
        ST_FIRE,
        ST_WAIT,
        ST_HOLD
    } fc_state_e;

    // Element idx of the activation vector lives at bits [idx*dw +: dw].
    function automatic int elem_lsb(input int idx, input int dw);
        return idx * dw;
    endfunction

endpackage

// File: rtl/fc_done_watchdog.sv
// Countdown watchdog bounding the wait for fc_done after the enable strobe.
// Ports: clk, rst_n, load_i (reload with TIMEOUT), dec_i (count down), expire_o (last allowed cycle).
module fc_done_watchdog
    import fc_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic expire_o
);

    logic [WD_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= WD_W'(TIMEOUT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WD_W'(1);
        end
    end

    // Counter holds TIMEOUT in the first wait cycle, so a value of 1
    // marks the TIMEOUT-th (final) cycle in which fc_done is still accepted.
    assign expire_o = dec_i && (cnt_q == WD_W'(1));

endmodule

// File: rtl/fc_feed_sequencer.sv
// Collects N_IN serial activations, strobes the FC layer and forwards its result.
// Ports: s_* upstream stream, fc_* FC layer control/data, m_* downstream result, err_timeout sticky.
module fc_feed_sequencer
    import fc_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int DW      = DW_DEF,
    parameter int OW      = OW_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [DW-1:0]    s_data,
    output logic             s_ready,
    output logic [N_IN*DW-1:0] fc_vec,
    output logic             fc_clr,
    output logic             fc_enable,
    input  logic             fc_done,
    input  logic [OW-1:0]    fc_result,
    output logic             m_valid,
    output logic [OW-1:0]    m_data,
    input  logic             m_ready,
    output logic             err_timeout
);

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    fc_state_e          state_q;
    logic [CNT_W-1:0]   count_q;
    logic [N_IN*DW-1:0] vec_q;
    logic               s_ready_q;
    logic               clr_q;
    logic               en_q;
    logic               m_valid_q;
    logic [OW-1:0]      m_data_q;
    logic               err_q;
    logic               wd_expire;

    fc_done_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q == ST_FIRE),
        .dec_i    (state_q == ST_WAIT),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            count_q   <= '0;
            vec_q     <= '0;
            s_ready_q <= 1'b0;
            clr_q     <= 1'b0;
            en_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            en_q  <= 1'b0;
            unique case (state_q)
                ST_FILL: begin
                    s_ready_q <= 1'b1;
                    if (s_valid && s_ready_q) begin
                        vec_q[elem_lsb(int'(count_q), DW) +: DW] <= s_data;
                        if (count_q == CNT_W'(N_IN - 1)) begin
                            count_q   <= '0;
                            s_ready_q <= 1'b0;
                            clr_q     <= 1'b1;
                            state_q   <= ST_CLEAR;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    en_q    <= 1'b1;
                    state_q <= ST_FIRE;
                end
                ST_FIRE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the final watchdog cycle still counts.
                    if (fc_done) begin
                        m_data_q  <= fc_result;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_HOLD;
                    end else if (wd_expire) begin
                        err_q     <= 1'b1;
                        count_q   <= '0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_FILL;
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_FILL;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign fc_vec      = vec_q;
    assign fc_clr      = clr_q;
    assign fc_enable   = en_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_fc_feed_sequencer.sv
// Directed plus randomized bench for fc_feed_sequencer with a frame-level reference model.
// Inputs are driven and outputs observed 1 time unit after each rising edge.
module tb_fc_feed_sequencer;

    localparam int N   = 9;
    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            s_valid = 1'b0;
    logic [DW-1:0]   s_data = '0;
    logic            s_ready;
    logic [N*DW-1:0] fc_vec;
    logic            fc_clr;
    logic            fc_enable;
    logic            fc_done = 1'b0;
    logic [OW-1:0]   fc_result = '0;
    logic            m_valid;
    logic [OW-1:0]   m_data;
    logic            m_ready = 1'b0;
    logic            err_timeout;

    int total = 0;
    int bad   = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    fc_feed_sequencer #(
        .N_IN    (N),
        .DW      (DW),
        .OW      (OW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .fc_vec      (fc_vec),
        .fc_clr      (fc_clr),
        .fc_enable   (fc_enable),
        .fc_done     (fc_done),
        .fc_result   (fc_result),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        fc_done = 1'b0;
        m_ready = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("rst_s_ready", 72'(s_ready), 72'(0));
        chk("rst_vec", 72'(fc_vec), 72'(0));
        chk("rst_clr", 72'(fc_clr), 72'(0));
        chk("rst_en", 72'(fc_enable), 72'(0));
        chk("rst_m_valid", 72'(m_valid), 72'(0));
        chk("rst_m_data", 72'(m_data), 72'(0));
        chk("rst_err", 72'(err_timeout), 72'(0));
        exp_err = 1'b0;
        @(negedge clk);
        chk("rst_hold_s_ready", 72'(s_ready), 72'(0));
        rst_n = 1'b1;
        tick();
        chk("rel_s_ready", 72'(s_ready), 72'(1));
    endtask

    // One FC evaluation. dly: cycles after enable at which done arrives,
    // outside 1..TMO means never. hold: cycles m_ready stays low in HOLD.
    task automatic run_frame(input logic [DW-1:0] v [N], input int gap,
                             input int dly, input logic [OW-1:0] res,
                             input int hold, input int abort_fill,
                             input bit abort_hold, input bit stray);
        int idx = 0;
        int guard = 0;
        logic [N*DW-1:0] ev;
        for (int i = 0; i < N; i++) ev[i*DW +: DW] = v[i];
        while (idx < N && guard < 300) begin
            if (idx == abort_fill) begin
                do_reset();
                return;
            end
            s_valid   = ($urandom_range(99) >= gap);
            s_data    = v[idx];
            fc_done   = stray && ($urandom_range(1) == 1);
            fc_result = OW'($urandom);
            m_ready   = 1'($urandom_range(1));
            chk("fill_m_valid", 72'(m_valid), 72'(0));
            chk("fill_clr", 72'(fc_clr), 72'(0));
            if (s_valid && s_ready) idx++;
            tick();
            guard++;
        end
        chk("fill_budget", 72'(idx), 72'(N));
        s_valid = 1'b0;
        fc_done = 1'b0;
        m_ready = 1'b0;
        chk("clr_pulse", 72'(fc_clr), 72'(1));
        chk("clr_en", 72'(fc_enable), 72'(0));
        chk("clr_s_ready", 72'(s_ready), 72'(0));
        for (int i = 0; i < N; i++)
            chk($sformatf("elem%0d", i), 72'(fc_vec[i*DW +: DW]), 72'(v[i]));
        tick();
        chk("en_pulse", 72'(fc_enable), 72'(1));
        chk("en_clr", 72'(fc_clr), 72'(0));
        tick();
        for (int k = 1; k <= TMO; k++) begin
            fc_done   = (k == dly);
            fc_result = res;
            chk("wait_m_valid", 72'(m_valid), 72'(0));
            chk("wait_en", 72'(fc_enable), 72'(0));
            chk("wait_err", 72'(err_timeout), 72'(exp_err));
            tick();
            fc_done = 1'b0;
            if (k == dly) break;
        end
        if (dly >= 1 && dly <= TMO) begin
            for (int h = 0; h < 64; h++) begin
                m_ready   = (h >= hold);
                fc_done   = 1'($urandom_range(1));
                fc_result = OW'($urandom);
                chk("hold_m_valid", 72'(m_valid), 72'(1));
                chk("hold_m_data", 72'(m_data), 72'(res));
                chk("hold_s_ready", 72'(s_ready), 72'(0));
                chk("hold_vec", 72'(fc_vec), 72'(ev));
                chk("hold_err", 72'(err_timeout), 72'(exp_err));
                if (abort_hold && h == 2) begin
                    do_reset();
                    return;
                end
                tick();
                if (m_ready) break;
            end
            m_ready = 1'b0;
            fc_done = 1'b0;
            chk("post_m_valid", 72'(m_valid), 72'(0));
            chk("post_s_ready", 72'(s_ready), 72'(1));
        end else begin
            exp_err = 1'b1;
            chk("tmo_err", 72'(err_timeout), 72'(1));
            chk("tmo_m_valid", 72'(m_valid), 72'(0));
            chk("tmo_s_ready", 72'(s_ready), 72'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [DW-1:0] v [N];
        #1;
        do_reset();

        v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        run_frame(v, 0, 1, 16'd285, 0, -1, 1'b0, 1'b0);

        v = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h05, 8'hFB, 8'h40, 8'hC0, 8'h01};
        run_frame(v, 40, 2, 16'hFED4, 10, -1, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) v[i] = DW'($urandom);
        run_frame(v, 10, 0, 16'h0000, 0, -1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) v[i] = DW'($urandom);
        run_frame(v, 20, 3, OW'($urandom), 2, -1, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < N; i++) v[i] = DW'($urandom);
        run_frame(v, 30, TMO, OW'($urandom), 1, -1, 1'b0, 1'b1);

        for (int i = 0; i < N; i++) v[i] = DW'($urandom);
        run_frame(v, 0, 1, OW'($urandom), 0, 5, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) v[i] = DW'(8'hA0 + i);
        run_frame(v, 0, 2, 16'h1234, 0, -1, 1'b0, 1'b0);

        run_frame(v, 0, 1, 16'h7FFF, 10, -1, 1'b1, 1'b0);
        chk("post_hold_rst_m_valid", 72'(m_valid), 72'(0));
        for (int i = 0; i < N; i++) v[i] = DW'($urandom);
        run_frame(v, 25, 1, OW'($urandom), 0, -1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) v[i] = DW'($urandom);
            run_frame(v, $urandom_range(0, 50), $urandom_range(1, TMO),
                      OW'($urandom), $urandom_range(0, 3), -1, 1'b0,
                      1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fc_feed_sequencer.md
Name: fc_feed_sequencer

Overview:
- Producer/controller on the input side of the fully-connected layer.
- Collects N_IN signed activations arriving serially from the upstream conv/pool stream over a valid/ready handshake, then presents them in parallel to the FC layer.
- Issues the FC clear and enable strobes, waits for the FC done, and forwards the FC result downstream over a second valid/ready handshake.
- A done-timeout watchdog sets a sticky error flag.

Parameters:
- N_IN, 9, number of activations per FC evaluation.
- DW, 8, activation width (signed).
- OW, 16, FC result width (signed).
- TIMEOUT, 64, max cycles to wait for fc_done after the enable strobe; range 1..2^16-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream activation valid.
- s_data  in  DW  upstream activation, signed.
- s_ready  out  1  sequencer can accept an activation.
- fc_vec  out  N_IN*DW  activation vector; element i at bits [i*DW +: DW].
- fc_clr  out  1  one-cycle active-high accumulator clear to the FC layer.
- fc_enable  out  1  one-cycle start strobe to the FC layer.
- fc_done  in  1  FC completion; fc_result is valid in the same cycle.
- fc_result  in  OW  FC output, signed.
- m_valid  out  1  result valid downstream.
- m_data  out  OW  captured result, signed.
- m_ready  in  1  downstream accepts the result.
- err_timeout  out  1  sticky; set on watchdog expiry.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State is FILL; count = 0; vector registers = 0.
  - s_ready=0 during reset, 1 in the first cycle after release.
  - fc_clr=0, fc_enable=0, m_valid=0, m_data=0, err_timeout=0.
- FILL:
  - s_ready=1.
  - Each cycle with s_valid&&s_ready writes s_data to element [count] and increments count.
  - On the transfer with count==N_IN-1: count wraps to 0, go to CLEAR.
  - Elements are filled in arrival order, element 0 first.
- CLEAR:
  - s_ready=0; fc_clr=1 for exactly one cycle; next state FIRE.
- FIRE:
  - fc_enable=1 for exactly one cycle; watchdog loaded with TIMEOUT; next state WAIT.
- WAIT:
  - fc_enable=0; watchdog decrements each cycle.
  - fc_done=1: capture fc_result into m_data, set m_valid=1, go to HOLD.
  - If fc_done and watchdog expiry fall in the same cycle, fc_done wins.
  - Watchdog reaches 0 without fc_done: set err_timeout, m_valid stays 0, return to FILL with count=0 (vector discarded).
- HOLD:
  - m_valid=1; m_data stable until m_valid&&m_ready.
  - On that handshake: m_valid=0, go to FILL.
  - s_ready=0 in HOLD; the next vector does not start until the result is consumed.
  - m_ready asserted in the first HOLD cycle gives a single-cycle m_valid.
- fc_vec is stable from CLEAR through HOLD and is only modified in FILL.
- fc_done outside WAIT is ignored.
- err_timeout clears only on reset.
- Minimum latency: last accepted activation at cycle t; CLEAR at t+1; FIRE at t+2; first possible m_valid at t+4 (done at t+3).
- No arithmetic in this block; values are passed through bit-exact with sign preserved.
- Reset asserted mid-operation (any state) aborts immediately: partial vector discarded, outputs return to reset values.

Decomposition:
- Shared package fc_pkg holds:
  - state enum (FILL, CLEAR, FIRE, WAIT, HOLD);
  - default constants N_IN=9, DW=8, OW=16;
  - the element-slicing convention for fc_vec.
- One natural sub-module: fc_done_watchdog (load, decrement, expire, TIMEOUT parameter).
- The rest is a single FSM with count and vector registers.

Test Plan:
- Basic:
  - Stimulus: stream 1..9 with s_valid held high; a model FC asserts done 1 cycle after enable with result 285; m_ready=1.
  - Required: fc_vec elements 0..8 = 1..9; fc_clr and fc_enable each high exactly 1 cycle, in consecutive cycles; m_data=285 for one cycle; s_ready returns to 1 the next cycle.
- Signed and backpressure:
  - Stimulus: stream -128,127,-1,0,5,-5,64,-64,1 with random s_valid gaps; FC returns -300; m_ready held low for 10 cycles.
  - Required: elements match bit-exact; m_valid held with m_data=0xFED4 for the full 10 cycles; s_ready=0 throughout.
- Timeout:
  - Stimulus: TIMEOUT=4, model FC never asserts done.
  - Required: err_timeout rises 4 cycles after the fc_enable cycle; m_valid never asserts; FSM is back in FILL and accepts 9 new values.
  - Required: a normal run afterwards succeeds with err_timeout still 1.
- Boundary:
  - Stimulus: fc_done arrives in the same cycle the watchdog expires; separately, a stray fc_done arrives during FILL.
  - Required: the first captures the result and err_timeout stays 0; the second is ignored.
- Reset mid-operation:
  - Stimulus: drop rst_n after 5 activations; separately, drop rst_n during HOLD.
  - Required: outputs go to reset values asynchronously; the next vector fills from element 0; no stale m_valid.
